// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter: FSM states, owner tag
// and the latched memory request.
package mem_port_arbiter_pkg;

    localparam int XLEN_W         = 32;
    localparam int STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;

    typedef enum logic {OWN_IF, OWN_D} owner_t;

    typedef struct packed {
        logic              we;
        logic [XLEN_W-1:0] addr;
        logic [XLEN_W-1:0] wdata;
        logic [3:0]        wstrb;
    } mem_req_t;

    // Loads never present byte enables to the memory.
    function automatic logic [3:0] storeStrb(input logic we, input logic [3:0] strb);
        return we ? strb : 4'b0000;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: one outstanding request, grant, and a single response.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

endinterface

// File: rtl/mem_port_arbiter_arb_prio.sv
// Winner select for the shared memory port: data side has priority, but a fetch
// kept waiting through STARVE_LIM consecutive data grants is forced through.
module arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ifReq,
    input  logic dReq,
    input  logic grant,
    output logic grantD
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starveCnt;
    logic          starved;

    assign starved = (starveCnt == CW'(STARVE_LIM)) && ifReq;
    assign grantD  = dReq && !starved;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (grant) begin
            if (grantD && ifReq) begin
                if (starveCnt != CW'(STARVE_LIM))
                    starveCnt <= starveCnt + CW'(1);
            end else begin
                starveCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store unit,
// one outstanding transaction at a time, and raises stalls while a requester waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_W,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_valid,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_valid,
    output logic              d_err,

    output logic              stall_if,
    output logic              stall_mem,

    mem_port_arbiter_if.master mem
);

    arb_state_t state, stateNext;
    owner_t     owner;
    mem_req_t   reqLatch;
    logic       grant;
    logic       grantD;
    logic       respTake;

    // Requests are only sampled in IDLE, so the one still held during RESP cannot re-issue.
    assign grant    = (state == IDLE) && (if_req || d_req);
    assign respTake = (state == WAIT) && mem.mem_rvalid;

    arb_prio #(
        .STARVE_LIM(STARVE_LIM)
    ) uPrio (
        .clk   (clk),
        .reset (reset),
        .ifReq (if_req),
        .dReq  (d_req),
        .grant (grant),
        .grantD(grantD)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // NOTE: stateNext takes its default first so no path through the case infers a latch.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grant)           stateNext = REQ;
            REQ:     if (mem.mem_gnt)     stateNext = WAIT;
            WAIT:    if (mem.mem_rvalid)  stateNext = RESP;
            RESP:                         stateNext = IDLE;
            default:                      stateNext = IDLE;
        endcase
    end

    // Request fields are captured once on leaving IDLE and stay frozen until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_IF;
            reqLatch <= '0;
        end else if (grant) begin
            if (grantD) begin
                owner    <= OWN_D;
                reqLatch <= '{we: d_we, addr: d_addr, wdata: d_wdata,
                              wstrb: storeStrb(d_we, d_wstrb)};
            end else begin
                owner    <= OWN_IF;
                reqLatch <= '{we: 1'b0, addr: if_addr, wdata: '0, wstrb: 4'b0000};
            end
        end
    end

    // Only the owner's response registers move; a store leaves d_rdata untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata <= '0;
            if_err   <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else if (respTake) begin
            if (owner == OWN_IF) begin
                if_rdata <= mem.mem_rdata;
                if_err   <= mem.mem_err;
            end else begin
                d_err <= mem.mem_err;
                if (!reqLatch.we)
                    d_rdata <= mem.mem_rdata;
            end
        end
    end

    assign if_valid  = (state == RESP) && (owner == OWN_IF);
    assign d_valid   = (state == RESP) && (owner == OWN_D);
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;

    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = reqLatch.we;
    assign mem.mem_addr  = reqLatch.addr;
    assign mem.mem_wdata = reqLatch.wdata;
    assign mem.mem_wstrb = reqLatch.wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory cycle by cycle
// and every expected value is written out by hand.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_valid;
    logic            if_err;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic [XLEN-1:0] d_rdata;
    logic            d_valid;
    logic            d_err;
    logic            stall_if;
    logic            stall_mem;

    int nChecks = 0;
    int nFails  = 0;

    mem_port_arbiter_if #(.XLEN(XLEN)) memBus ();

    mem_port_arbiter #(
        .XLEN      (XLEN),
        .STARVE_LIM(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_err    (d_err),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem      (memBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'b0000;
        memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b0;
        memBus.mem_rdata = '0; memBus.mem_err = 1'b0;

        // Reset state
        step(); step(); settle();
        check("rst_if_valid",  32'(if_valid),         0);
        check("rst_d_valid",   32'(d_valid),          0);
        check("rst_if_err",    32'(if_err),           0);
        check("rst_d_err",     32'(d_err),            0);
        check("rst_if_rdata",  if_rdata,              0);
        check("rst_d_rdata",   d_rdata,               0);
        check("rst_mem_req",   32'(memBus.mem_req),   0);
        check("rst_mem_we",    32'(memBus.mem_we),    0);
        check("rst_mem_addr",  memBus.mem_addr,       0);
        check("rst_mem_wdata", memBus.mem_wdata,      0);
        check("rst_mem_wstrb", 32'(memBus.mem_wstrb), 0);
        check("rst_stall_if",  32'(stall_if),         0);
        check("rst_stall_mem", 32'(stall_mem),        0);

        // 1. Lone fetch, minimum latency
        step(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h100; memBus.mem_gnt = 1'b1; settle();
        check("t1_c0_stall_if", 32'(stall_if),       1);
        check("t1_c0_mem_req",  32'(memBus.mem_req), 0);
        step(); settle();
        check("t1_c1_mem_req",   32'(memBus.mem_req),   1);
        check("t1_c1_mem_addr",  memBus.mem_addr,       32'h100);
        check("t1_c1_mem_we",    32'(memBus.mem_we),    0);
        check("t1_c1_mem_wstrb", 32'(memBus.mem_wstrb), 0);
        check("t1_c1_stall_if",  32'(stall_if),         1);
        step(); memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h00500093; settle();
        check("t1_c2_mem_req",  32'(memBus.mem_req), 0);
        check("t1_c2_if_valid", 32'(if_valid),       0);
        check("t1_c2_stall_if", 32'(stall_if),       1);
        step(); memBus.mem_rvalid = 1'b0; settle();
        check("t1_c3_if_valid", 32'(if_valid), 1);
        check("t1_c3_if_rdata", if_rdata,      32'h00500093);
        check("t1_c3_if_err",   32'(if_err),   0);
        check("t1_c3_stall_if", 32'(stall_if), 0);
        check("t1_c3_d_valid",  32'(d_valid),  0);
        step(); if_req = 1'b0; settle();
        check("t1_c4_if_valid", 32'(if_valid), 0);

        // 2. Simultaneous requests: D first, IF on the next IDLE
        step(); if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; settle();
        check("t2_c0_stall_mem", 32'(stall_mem), 1);
        step(); settle();
        check("t2_c1_mem_addr", memBus.mem_addr,    32'h2000);
        check("t2_c1_mem_we",   32'(memBus.mem_we), 0);
        check("t2_c1_stall_if", 32'(stall_if),      1);
        step(); memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'hCAFE0001; settle();
        step(); memBus.mem_rvalid = 1'b0; settle();
        check("t2_c3_d_valid",   32'(d_valid),   1);
        check("t2_c3_d_rdata",   d_rdata,        32'hCAFE0001);
        check("t2_c3_if_valid",  32'(if_valid),  0);
        check("t2_c3_if_rdata",  if_rdata,       32'h00500093);
        check("t2_c3_stall_mem", 32'(stall_mem), 0);
        step(); d_req = 1'b0; settle();
        check("t2_c4_d_valid", 32'(d_valid),       0);
        check("t2_c4_mem_req", 32'(memBus.mem_req), 0);
        step(); settle();
        check("t2_c5_mem_addr", memBus.mem_addr, 32'h104);
        step(); memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h00000013; settle();
        check("t2_c6_if_valid", 32'(if_valid), 0);
        step(); memBus.mem_rvalid = 1'b0; settle();
        check("t2_c7_if_valid", 32'(if_valid), 1);
        check("t2_c7_if_rdata", if_rdata,      32'h00000013);
        check("t2_c7_d_rdata",  d_rdata,       32'hCAFE0001);
        step(); if_req = 1'b0; settle();

        // 3. Starvation: rvalid held high, stray copies outside WAIT are ignored
        step();
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wstrb = 4'hF;
        memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h11111111;
        settle();
        for (int k = 0; k < 6; k++) begin
            step(); settle();
            check($sformatf("t3_k%0d_mem_addr", k), memBus.mem_addr, (k == 4) ? 32'h200 : 32'h3000);
            check($sformatf("t3_k%0d_mem_wstrb", k), 32'(memBus.mem_wstrb), 0);
            check($sformatf("t3_k%0d_starve_cnt", k), 32'(dut.uPrio.starveCnt),
                  (k == 4) ? 0 : ((k == 5) ? 1 : k + 1));
            step(); settle();
            step(); settle();
            check($sformatf("t3_k%0d_if_valid", k), 32'(if_valid), (k == 4) ? 1 : 0);
            check($sformatf("t3_k%0d_d_valid", k),  32'(d_valid),  (k == 4) ? 0 : 1);
            step();
            if (k == 5) begin
                if_req = 1'b0; d_req = 1'b0; d_wstrb = 4'b0000; memBus.mem_rvalid = 1'b0;
            end
            settle();
        end

        // 4. Store with grant held off for 3 cycles; request fields stay frozen
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        memBus.mem_gnt = 1'b0; memBus.mem_rdata = 32'h55555555;
        settle();
        for (int w = 0; w < 3; w++) begin
            step(); d_addr = 32'hFFFF0000 + w; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'b1100; settle();
            check($sformatf("t4_w%0d_mem_req", w),   32'(memBus.mem_req),   1);
            check($sformatf("t4_w%0d_mem_we", w),    32'(memBus.mem_we),    1);
            check($sformatf("t4_w%0d_mem_addr", w),  memBus.mem_addr,       32'h40);
            check($sformatf("t4_w%0d_mem_wdata", w), memBus.mem_wdata,      32'hDEADBEEF);
            check($sformatf("t4_w%0d_mem_wstrb", w), 32'(memBus.mem_wstrb), 32'h3);
        end
        step(); memBus.mem_gnt = 1'b1; settle();
        check("t4_c4_mem_req",  32'(memBus.mem_req), 1);
        check("t4_c4_mem_addr", memBus.mem_addr,     32'h40);
        check("t4_c4_d_valid",  32'(d_valid),        0);
        step(); memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b1; settle();
        check("t4_c5_stall_mem", 32'(stall_mem), 1);
        step(); memBus.mem_rvalid = 1'b0; settle();
        check("t4_c6_d_valid",  32'(d_valid),  1);
        check("t4_c6_d_err",    32'(d_err),    0);
        check("t4_c6_d_rdata",  d_rdata,       32'h11111111);
        check("t4_c6_if_valid", 32'(if_valid), 0);
        step(); d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0000; settle();

        // 5. Bus error on a fetch
        step(); if_req = 1'b1; if_addr = 32'h300; memBus.mem_gnt = 1'b1; settle();
        step(); settle();
        check("t5_c1_mem_addr", memBus.mem_addr, 32'h300);
        step(); memBus.mem_rvalid = 1'b1; memBus.mem_err = 1'b1; memBus.mem_rdata = 32'hBAD0BAD0; settle();
        step(); memBus.mem_rvalid = 1'b0; memBus.mem_err = 1'b0; settle();
        check("t5_c3_if_valid", 32'(if_valid), 1);
        check("t5_c3_if_err",   32'(if_err),   1);
        check("t5_c3_if_rdata", if_rdata,      32'hBAD0BAD0);
        check("t5_c3_d_valid",  32'(d_valid),  0);
        check("t5_c3_d_err",    32'(d_err),    0);
        check("t5_c3_d_rdata",  d_rdata,       32'h11111111);
        step(); if_req = 1'b0; settle();
        check("t5_c4_if_valid", 32'(if_valid), 0);

        // 6. Reset in WAIT, stray response afterwards, then a fresh fetch
        step(); if_req = 1'b1; if_addr = 32'h400; settle();
        step(); settle();
        check("t6_c1_mem_addr", memBus.mem_addr, 32'h400);
        step(); reset = 1'b1; settle();
        step(); reset = 1'b0; if_req = 1'b0; memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h77777777; settle();
        check("t6_c3_mem_req",  32'(memBus.mem_req), 0);
        check("t6_c3_mem_addr", memBus.mem_addr,     0);
        check("t6_c3_if_valid", 32'(if_valid),       0);
        check("t6_c3_d_valid",  32'(d_valid),        0);
        check("t6_c3_if_rdata", if_rdata,            0);
        check("t6_c3_if_err",   32'(if_err),         0);
        check("t6_c3_d_rdata",  d_rdata,             0);
        step(); memBus.mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h404; settle();
        check("t6_c4_mem_req",  32'(memBus.mem_req), 0);
        check("t6_c4_if_valid", 32'(if_valid),       0);
        check("t6_c4_if_rdata", if_rdata,            0);
        step(); settle();
        check("t6_c5_mem_req",  32'(memBus.mem_req), 1);
        check("t6_c5_mem_addr", memBus.mem_addr,     32'h404);
        step(); memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h00000073; settle();
        step(); memBus.mem_rvalid = 1'b0; settle();
        check("t6_c7_if_valid", 32'(if_valid), 1);
        check("t6_c7_if_rdata", if_rdata,      32'h00000073);
        check("t6_c7_if_err",   32'(if_err),   0);
        step(); if_req = 1'b0; settle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
